dpb_ptr_sched: RTL and testbench

- Pointer scheduler inside the egress dirty pointer broker.
- Keeps a local cache of dirty pointers and refills it in batches from PFS through a request FSM.
- Shares the cache between the TMU and PRC consumers with a one-pointer-per-cycle round-robin arbiter.
- Replaces ad-hoc per-consumer PFS requests with a single sequenced refill path.

---
 rtl/dpb_pkg.sv | 17 +
 rtl/dpb_ptr_sched_if.sv | 28 ++
 rtl/dpb_ptr_fifo.sv | 52 +++++
 rtl/dpb_ptr_sched.sv | 106 ++++++++++
 tb/tb_dpb_ptr_sched.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/dpb_pkg.sv
// Shared types and default sizing for the dirty pointer broker scheduler.
package dpb_pkg;

  localparam int PTR_W_DEF  = 16;
  localparam int DEPTH_DEF  = 32;
  localparam int BATCH_DEF  = 8;
  localparam int LOW_WM_DEF = 8;

  typedef logic [PTR_W_DEF-1:0] dpb_ptr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } dpb_refill_state_e;

endpackage

// File: rtl/dpb_ptr_sched_if.sv
// Consumer (TMU/PRC) and PFS refill signals of the pointer scheduler.
interface dpb_ptr_sched_if #(
  parameter int PTR_W = 16,
  parameter int CNT_W = 4
);
  logic             tmu_req;
  logic             tmu_gnt;
  logic [PTR_W-1:0] tmu_ptr;
  logic             prc_req;
  logic             prc_gnt;
  logic [PTR_W-1:0] prc_ptr;
  logic             pfs_req_valid;
  logic             pfs_req_ready;
  logic [CNT_W-1:0] pfs_req_cnt;
  logic             pfs_rsp_valid;
  logic [PTR_W-1:0] pfs_rsp_ptr;

  // master is the scheduler, slave is the consumers plus PFS
  modport master (
    input  tmu_req, prc_req, pfs_req_ready, pfs_rsp_valid, pfs_rsp_ptr,
    output tmu_gnt, tmu_ptr, prc_gnt, prc_ptr, pfs_req_valid, pfs_req_cnt
  );

  modport slave (
    output tmu_req, prc_req, pfs_req_ready, pfs_rsp_valid, pfs_rsp_ptr,
    input  tmu_gnt, tmu_ptr, prc_gnt, prc_ptr, pfs_req_valid, pfs_req_cnt
  );
endinterface

// File: rtl/dpb_ptr_fifo.sv
// Pointer cache: DEPTH-entry FIFO with wrapping read/write pointers and occupancy.
module dpb_ptr_fifo
  import dpb_pkg::*;
#(
  parameter  int PTR_W = PTR_W_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [PTR_W-1:0] din_i,
  input  logic             pop_i,
  output logic [PTR_W-1:0] head_o,
  output logic [OCC_W-1:0] count_o
);

  logic [PTR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [OCC_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      count_q <= count_d;
    end
  end

  // storage needs no reset; occupancy alone says which entries are live
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/dpb_ptr_sched.sv
// Pointer scheduler: cached dirty pointers shared by TMU/PRC, refilled in batches from PFS.
//   state | meaning
//   IDLE  | no batch in flight; start one when enabled and cache below LOW_WM
//   REQ   | batch request held on PFS until accepted
//   WAIT  | collecting the outstanding pointers of the accepted batch
module dpb_ptr_sched
  import dpb_pkg::*;
#(
  parameter  int PTR_W  = PTR_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int BATCH  = BATCH_DEF,
  parameter  int LOW_WM = LOW_WM_DEF,
  localparam int CNT_W  = $clog2(BATCH + 1),
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en_i,
  dpb_ptr_sched_if.master  bus,
  output logic [OCC_W-1:0] occupancy_o,
  output logic             err_unexp_rsp_o
);

  dpb_refill_state_e state_q, state_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic              last_tmu_q, last_tmu_d;
  logic              err_q, err_d;
  logic              rsp_ok, pop;
  logic [PTR_W-1:0]  head;
  logic [OCC_W-1:0]  count;

  dpb_ptr_fifo #(.PTR_W(PTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_ok),
    .din_i   (bus.pfs_rsp_ptr),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  // round-robin: on contention the side not granted last wins
  always_comb begin
    bus.tmu_gnt = 1'b0;
    bus.prc_gnt = 1'b0;
    if (count != '0) begin
      if (bus.tmu_req && (!bus.prc_req || !last_tmu_q)) bus.tmu_gnt = 1'b1;
      else if (bus.prc_req)                             bus.prc_gnt = 1'b1;
    end
    pop        = bus.tmu_gnt | bus.prc_gnt;
    last_tmu_d = bus.tmu_gnt ? 1'b1 : (bus.prc_gnt ? 1'b0 : last_tmu_q);
  end

  assign bus.tmu_ptr = (count != '0) ? head : '0;
  assign bus.prc_ptr = (count != '0) ? head : '0;

  always_comb begin
    state_d           = state_q;
    outst_d           = outst_q;
    rsp_ok            = 1'b0;
    bus.pfs_req_valid = 1'b0;
    bus.pfs_req_cnt   = '0;
    case (state_q)
      IDLE: begin
        if (cfg_en_i && (count < OCC_W'(LOW_WM)) && (outst_q == '0)) state_d = REQ;
      end
      REQ: begin
        bus.pfs_req_valid = 1'b1;
        bus.pfs_req_cnt   = CNT_W'(BATCH);
        if (bus.pfs_req_ready) begin
          // a response in the handshake cycle already belongs to this batch
          rsp_ok  = bus.pfs_rsp_valid;
          outst_d = CNT_W'(BATCH) - CNT_W'(bus.pfs_rsp_valid);
          state_d = (outst_d == '0) ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (bus.pfs_rsp_valid) begin
          rsp_ok  = 1'b1;
          outst_d = outst_q - CNT_W'(1);
          if (outst_q == CNT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    err_d = err_q | (bus.pfs_rsp_valid & ~rsp_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      outst_q    <= '0;
      last_tmu_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      outst_q    <= outst_d;
      last_tmu_q <= last_tmu_d;
      err_q      <= err_d;
    end
  end

  assign occupancy_o     = count;
  assign err_unexp_rsp_o = err_q;

endmodule

// File: tb/tb_dpb_ptr_sched.sv
// Directed bench for dpb_ptr_sched: expected grants queued at stimulus, checked by a monitor.
module tb_dpb_ptr_sched;
  import dpb_pkg::*;

  localparam logic [1:0] NONE = 2'b00, TMU = 2'b10, PRC = 2'b01;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_en = 1'b0;
  logic [5:0] occupancy;
  logic       err;

  dpb_ptr_sched_if #(.PTR_W(16), .CNT_W(4)) bus ();

  dpb_ptr_sched dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_en_i        (cfg_en),
    .bus             (bus),
    .occupancy_o     (occupancy),
    .err_unexp_rsp_o (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] side;
    dpb_ptr_t   ptr;
  } exp_t;

  int       n_chk  = 0;
  int       n_fail = 0;
  int       hs_cnt = 0;
  int       hs0;
  exp_t     sb[$];
  dpb_ptr_t model[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.pfs_req_valid && bus.pfs_req_ready) hs_cnt++;
    if (bus.tmu_gnt || bus.prc_gnt) begin
      if (sb.size() == 0) begin
        check("unexpected_grant", {30'b0, bus.tmu_gnt, bus.prc_gnt}, 32'(NONE));
      end else begin
        e = sb.pop_front();
        check("grant_side", {30'b0, bus.tmu_gnt, bus.prc_gnt}, {30'b0, e.side});
        check("grant_ptr", bus.tmu_gnt ? bus.tmu_ptr : bus.prc_ptr, e.ptr);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // one cycle of stimulus; side is the hand-computed grant, ptr comes from the cache model
  task automatic cyc(input logic t, input logic p, input logic rv, input dpb_ptr_t rp,
                     input logic [1:0] side, input logic acc);
    exp_t e;
    bus.tmu_req       = t;
    bus.prc_req       = p;
    bus.pfs_rsp_valid = rv;
    bus.pfs_rsp_ptr   = rp;
    if (side != NONE) begin
      e.side = side;
      e.ptr  = model.pop_front();
      sb.push_back(e);
    end
    if (rv && acc) model.push_back(rp);
    @(negedge clk);
    check("grant_vec", {30'b0, bus.tmu_gnt, bus.prc_gnt}, {30'b0, side});
    tick();
    bus.tmu_req       = 1'b0;
    bus.prc_req       = 1'b0;
    bus.pfs_rsp_valid = 1'b0;
  endtask

  task automatic do_refill;
    int w = 0;
    while (!bus.pfs_req_valid && w < 20) begin
      tick();
      w++;
    end
    check("req_seen", bus.pfs_req_valid, 1);
    check("req_cnt", bus.pfs_req_cnt, 8);
    bus.pfs_req_ready = 1'b1;
    tick();
    bus.pfs_req_ready = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tmu_gnt"}, bus.tmu_gnt, 0);
    check({tag, "_prc_gnt"}, bus.prc_gnt, 0);
    check({tag, "_tmu_ptr"}, bus.tmu_ptr, 0);
    check({tag, "_prc_ptr"}, bus.prc_ptr, 0);
    check({tag, "_req_valid"}, bus.pfs_req_valid, 0);
    check({tag, "_req_cnt"}, bus.pfs_req_cnt, 0);
    check({tag, "_occupancy"}, occupancy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.tmu_req       = 1'b0;
    bus.prc_req       = 1'b0;
    bus.pfs_req_ready = 1'b0;
    bus.pfs_rsp_valid = 1'b0;
    bus.pfs_rsp_ptr   = '0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;

    // cold start
    cfg_en = 1'b1;
    hs0 = hs_cnt;
    do_refill();
    check("cold_handshakes", hs_cnt, hs0 + 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, dpb_ptr_t'(16'h10 + i), NONE, 1);
    check("cold_occupancy", occupancy, 8);
    for (int i = 0; i < 3; i++) begin
      check("cold_no_second_req", bus.pfs_req_valid, 0);
      tick();
    end
    check("cold_single_handshake", hs_cnt, hs0 + 1);

    // contention: alternate starting with TMU
    cyc(1, 1, 0, '0, TMU, 0);
    cyc(1, 1, 0, '0, PRC, 0);
    cyc(1, 1, 0, '0, TMU, 0);
    cyc(1, 1, 0, '0, PRC, 0);
    check("contention_occupancy", occupancy, 4);
    check("contention_refill_req", bus.pfs_req_valid, 1);

    // backpressure: request held stable while PFS not ready
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_stable", bus.pfs_req_valid, 1);
      check("bp_cnt_stable", bus.pfs_req_cnt, 8);
      tick();
    end
    bus.pfs_req_ready = 1'b1;
    tick();
    bus.pfs_req_ready = 1'b0;
    check("bp_single_handshake", hs_cnt, hs0 + 1);
    check("bp_valid_dropped", bus.pfs_req_valid, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, dpb_ptr_t'(16'h30 + i), NONE, 1);
    check("bp_occupancy", occupancy, 12);
    check("bp_err_clear", err, 0);

    // drain, then empty stall
    cfg_en = 1'b0;
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, '0, TMU, 0);
    check("drain_occupancy", occupancy, 0);
    cyc(1, 1, 0, '0, NONE, 0);
    cfg_en = 1'b1;
    do_refill();
    cfg_en = 1'b0;
    cyc(1, 0, 1, 16'h20, NONE, 1);
    cyc(1, 0, 0, '0, TMU, 0);
    for (int i = 1; i < 8; i++) cyc(0, 0, 1, dpb_ptr_t'(16'h20 + i), NONE, 1);
    check("stall_occupancy", occupancy, 7);
    check("stall_err_clear", err, 0);

    // 40 pointers through the cache with push and pop together
    cfg_en = 1'b1;
    for (int b = 0; b < 5; b++) begin
      do_refill();
      for (int i = 0; i < 8; i++) begin
        check("wrap_occ_steady", occupancy, 7);
        cyc(1, 0, 1, dpb_ptr_t'(16'h40 + b * 8 + i), TMU, 1);
      end
    end
    cfg_en = 1'b0;
    check("wrap_occupancy", occupancy, 7);
    check("wrap_err_clear", err, 0);

    // unexpected response in IDLE
    cyc(0, 0, 1, 16'h00EE, NONE, 0);
    check("unexp_err_set", err, 1);
    check("unexp_occ_unchanged", occupancy, 7);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, '0, PRC, 0);
    check("final_drain_occ", occupancy, 0);
    check("err_sticky", err, 1);

    // reset in the middle of a batch
    cfg_en = 1'b1;
    do_refill();
    cyc(0, 0, 1, 16'h70, NONE, 1);
    cyc(0, 0, 1, 16'h71, NONE, 1);
    check("midbatch_occ", occupancy, 2);
    cfg_en = 1'b0;
    rst = 1'b1;
    tick();
    check_zero("midreset");
    rst = 1'b0;
    model.delete();
    tick();
    check_zero("postreset");

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
